// File: rtl/float_mul_if.sv
// Operand/result handshake bundle for the pipelined floating-point multiplier.
// The slave side is the multiplier; the master side feeds operands and drains results.
interface float_mul_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         flag_ovf;
  logic         flag_unf;
  logic         flag_inv;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, flag_ovf, flag_unf, flag_inv
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, flag_ovf, flag_unf, flag_inv
  );
endinterface

// File: rtl/float_mul_pipe.sv
// Pipelined IEEE-style multiplier: operand capture, unpack/classify, product, round/pack.
// Denormal inputs flush to zero; results round to nearest even with ovf/unf/inv flags.
module float_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic      clk,
  input logic      rst_n,
  float_mul_if.slave bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 1;
  localparam int PW = 2 * MAN_W + 2;
  localparam int EW = EXP_W + 2;
  localparam int BIAS_I = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX_I = (1 << EXP_W) - 1;
  localparam logic signed [EW-1:0] BIAS = EW'(BIAS_I);
  localparam logic signed [EW-1:0] EXP_MAX = EW'(EMAX_I);
  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};

  typedef enum logic [1:0] {K_NORM = 2'd0, K_INV = 2'd1, K_INF = 2'd2, K_ZERO = 2'd3} kind_t;

  // stage registers: 0 = operand capture, 1 = classified, 2 = product, 3 = output
  logic                 v0_r, v1_r, v2_r, v3_r;
  logic [W-1:0]         a0_r, b0_r;
  logic                 sign1_r, sign2_r;
  kind_t                kind1_r, kind2_r;
  logic signed [EW-1:0] e1_r, e2_r;
  logic [SW-1:0]        siga1_r, sigb1_r;
  logic [PW-1:0]        prod2_r;
  logic [W-1:0]         result_r;
  logic                 ovf_r, unf_r, inv_r;

  logic en0_s, en1_s, en2_s, en3_s;

  // a stage may load when empty or when the stage after it loads this cycle
  always_comb begin
    en3_s = !v3_r || bus.out_ready;
    en2_s = !v2_r || en3_s;
    en1_s = !v1_r || en2_s;
    en0_s = !v0_r || en1_s;
  end

  assign bus.in_ready  = en0_s;
  assign bus.out_valid = v3_r;
  assign bus.result    = result_r;
  assign bus.flag_ovf  = ovf_r;
  assign bus.flag_unf  = unf_r;
  assign bus.flag_inv  = inv_r;

  logic [EXP_W-1:0]     ea_s, eb_s;
  logic [MAN_W-1:0]     ma_s, mb_s;
  logic                 zero_a_s, zero_b_s, inf_a_s, inf_b_s, nan_a_s, nan_b_s;
  kind_t                kind_s;
  logic signed [EW-1:0] e_sum_s;

  // classify captured operands; special-value priority is inv > inf > zero
  always_comb begin
    ea_s     = a0_r[W-2 -: EXP_W];
    eb_s     = b0_r[W-2 -: EXP_W];
    ma_s     = a0_r[MAN_W-1:0];
    mb_s     = b0_r[MAN_W-1:0];
    zero_a_s = (ea_s == {EXP_W{1'b0}});
    zero_b_s = (eb_s == {EXP_W{1'b0}});
    inf_a_s  = (ea_s == EXP_ONES) && (ma_s == {MAN_W{1'b0}});
    inf_b_s  = (eb_s == EXP_ONES) && (mb_s == {MAN_W{1'b0}});
    nan_a_s  = (ea_s == EXP_ONES) && (ma_s != {MAN_W{1'b0}});
    nan_b_s  = (eb_s == EXP_ONES) && (mb_s != {MAN_W{1'b0}});
    e_sum_s  = $signed({2'b00, ea_s}) + $signed({2'b00, eb_s}) - BIAS;
    if (nan_a_s || nan_b_s || (inf_a_s && zero_b_s) || (zero_a_s && inf_b_s)) begin
      kind_s = K_INV;
    end else if (inf_a_s || inf_b_s) begin
      kind_s = K_INF;
    end else if (zero_a_s || zero_b_s) begin
      kind_s = K_ZERO;
    end else begin
      kind_s = K_NORM;
    end
  end

  logic [PW-2:0]        norm_s;
  logic [MAN_W-1:0]     man_s;
  logic                 guard_s, sticky_s, inc_s;
  logic [MAN_W:0]       rnd_s;
  logic signed [EW-1:0] e_fin_s;
  logic [W-1:0]         pack_s;
  logic                 ovf_s, unf_s, inv_s;

  // normalise the product, round to nearest even and pack the result word
  always_comb begin
    norm_s   = prod2_r[PW-1] ? prod2_r[PW-2:0] : {prod2_r[PW-3:0], 1'b0};
    man_s    = norm_s[PW-2 -: MAN_W];
    guard_s  = norm_s[MAN_W];
    sticky_s = |norm_s[MAN_W-1:0];
    inc_s    = guard_s && (sticky_s || man_s[0]);
    rnd_s    = {1'b0, man_s} + {{MAN_W{1'b0}}, inc_s};
    e_fin_s  = e2_r + EW'(prod2_r[PW-1]) + EW'(rnd_s[MAN_W]);
    pack_s   = {W{1'b0}};
    ovf_s    = 1'b0;
    unf_s    = 1'b0;
    inv_s    = 1'b0;
    case (kind2_r)
      K_INV: begin
        pack_s = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
        inv_s  = 1'b1;
      end
      K_INF: begin
        pack_s = {sign2_r, EXP_ONES, {MAN_W{1'b0}}};
      end
      K_ZERO: begin
        pack_s = {sign2_r, {(EXP_W+MAN_W){1'b0}}};
      end
      K_NORM: begin
        if (e_fin_s >= EXP_MAX) begin
          pack_s = {sign2_r, EXP_ONES, {MAN_W{1'b0}}};
          ovf_s  = 1'b1;
        end else if (e_fin_s <= $signed({EW{1'b0}})) begin
          pack_s = {sign2_r, {(EXP_W+MAN_W){1'b0}}};
          unf_s  = 1'b1;
        end else begin
          pack_s = {sign2_r, e_fin_s[EXP_W-1:0], rnd_s[MAN_W-1:0]};
        end
      end
      default: begin
        pack_s = {W{1'b0}};
      end
    endcase
  end

  // pipeline advance; data registers only load when the upstream slot is valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_r     <= 1'b0;
      v1_r     <= 1'b0;
      v2_r     <= 1'b0;
      v3_r     <= 1'b0;
      a0_r     <= {W{1'b0}};
      b0_r     <= {W{1'b0}};
      sign1_r  <= 1'b0;
      sign2_r  <= 1'b0;
      kind1_r  <= K_ZERO;
      kind2_r  <= K_ZERO;
      e1_r     <= {EW{1'b0}};
      e2_r     <= {EW{1'b0}};
      siga1_r  <= {SW{1'b0}};
      sigb1_r  <= {SW{1'b0}};
      prod2_r  <= {PW{1'b0}};
      result_r <= {W{1'b0}};
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
      inv_r    <= 1'b0;
    end else begin
      if (en0_s) begin
        v0_r <= bus.in_valid;
        if (bus.in_valid) begin
          a0_r <= bus.a;
          b0_r <= bus.b;
        end
      end
      if (en1_s) begin
        v1_r <= v0_r;
        if (v0_r) begin
          sign1_r <= a0_r[W-1] ^ b0_r[W-1];
          kind1_r <= kind_s;
          e1_r    <= e_sum_s;
          siga1_r <= {1'b1, ma_s};
          sigb1_r <= {1'b1, mb_s};
        end
      end
      if (en2_s) begin
        v2_r <= v1_r;
        if (v1_r) begin
          sign2_r <= sign1_r;
          kind2_r <= kind1_r;
          e2_r    <= e1_r;
          prod2_r <= siga1_r * sigb1_r;
        end
      end
      if (en3_s) begin
        v3_r <= v2_r;
        if (v2_r) begin
          result_r <= pack_s;
          ovf_r    <= ovf_s;
          unf_r    <= unf_s;
          inv_r    <= inv_s;
        end
      end
    end
  end
endmodule

// File: tb/tb_float_mul_pipe.sv
// Directed bench for float_mul_pipe: expected words are queued on acceptance
// and compared in order as results leave the pipeline.
module tb_float_mul_pipe;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  float_mul_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

  float_mul_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // expected word layout: {result[31:0], ovf, unf, inv}
  logic [34:0] sb[$];
  logic [34:0] cur_exp;
  logic [34:0] held;
  int total = 0;
  int bad = 0;
  int cycle = 0;
  int acc_cycle = 0;
  int first_ov = -1;
  int base = 0;
  int out_count = 0;
  bit accepted = 1'b0;
  bit stalled = 1'b0;
  bit stall_en = 1'b0;
  bit saw_full = 1'b0;

  function automatic logic [34:0] mk(input logic [31:0] r, input logic o, input logic u, input logic i);
    return {r, o, u, i};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic sample();
    logic [34:0] got;
    logic [34:0] want;
    cycle++;
    got = {bus.result, bus.flag_ovf, bus.flag_unf, bus.flag_inv};
    if (bus.in_valid && bus.in_ready) begin
      sb.push_back(cur_exp);
      accepted = 1'b1;
      acc_cycle = cycle;
    end
    if (bus.in_valid && !bus.in_ready) saw_full = 1'b1;
    if (bus.out_valid && first_ov < 0) first_ov = cycle;
    if (bus.out_valid && stalled) check("hold_stable", {29'd0, got}, {29'd0, held});
    if (bus.out_valid && bus.out_ready) begin
      out_count++;
      if (sb.size() == 0) begin
        check("no_stale_out", {63'd0, bus.out_valid}, 64'd0);
      end else begin
        want = sb.pop_front();
        check("result", {29'd0, got}, {29'd0, want});
      end
    end
    stalled = bus.out_valid && !bus.out_ready;
    held = got;
  endtask

  task automatic tick();
    int k;
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    k = cycle - base + 1;
    if (stall_en) bus.out_ready = !(k >= 2 && k <= 6);
    else bus.out_ready = 1'b1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [34:0] e);
    bus.a = a;
    bus.b = b;
    bus.in_valid = 1'b1;
    cur_exp = e;
    accepted = 1'b0;
    for (int k = 0; k < 50 && !accepted; k++) tick();
    if (!accepted) check("accept_timeout", 64'd0, 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && sb.size() > 0; k++) tick();
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int a_c;
    bus.in_valid = 1'b0;
    bus.a = 32'h0;
    bus.b = 32'h0;
    bus.out_ready = 1'b1;
    cur_exp = 35'd0;
    held = 35'd0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {28'd0, bus.out_valid, bus.result, bus.flag_ovf, bus.flag_unf, bus.flag_inv}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_reset", {63'd0, bus.in_ready}, 64'd1);

    // basic product and latency: out_valid first seen after the third edge past acceptance
    first_ov = -1;
    send(32'h3FC00000, 32'h40000000, mk(32'h40400000, 1'b0, 1'b0, 1'b0));
    a_c = acc_cycle;
    drain();
    check("latency", 64'(first_ov - a_c), 64'd4);

    // rounding
    send(32'h3F800001, 32'h3F800001, mk(32'h3F800002, 1'b0, 1'b0, 1'b0));
    send(32'h3F800800, 32'h3F800800, mk(32'h3F801000, 1'b0, 1'b0, 1'b0));
    // range limits
    send(32'h7F000000, 32'h40000000, mk(32'h7F800000, 1'b1, 1'b0, 1'b0));
    send(32'h00800000, 32'h80800000, mk(32'h80000000, 1'b0, 1'b1, 1'b0));
    // special values
    send(32'h7F800000, 32'h00000000, mk(32'h7FC00000, 1'b0, 1'b0, 1'b1));
    send(32'hFF800000, 32'h40000000, mk(32'hFF800000, 1'b0, 1'b0, 1'b0));
    send(32'h7FC00001, 32'h3F800000, mk(32'h7FC00000, 1'b0, 1'b0, 1'b1));
    send(32'h00400000, 32'hC0000000, mk(32'h80000000, 1'b0, 1'b0, 1'b0));
    send(32'h80000000, 32'hFF800000, mk(32'h7FC00000, 1'b0, 1'b0, 1'b1));
    drain();

    // eight back-to-back operations with a downstream stall
    base = cycle;
    stall_en = 1'b1;
    saw_full = 1'b0;
    out_count = 0;
    send(32'h3F800000, 32'h3F800000, mk(32'h3F800000, 1'b0, 1'b0, 1'b0));
    send(32'h40000000, 32'h40400000, mk(32'h40C00000, 1'b0, 1'b0, 1'b0));
    send(32'h3FC00000, 32'h3FC00000, mk(32'h40100000, 1'b0, 1'b0, 1'b0));
    send(32'hC0000000, 32'h3F000000, mk(32'hBF800000, 1'b0, 1'b0, 1'b0));
    send(32'h40400000, 32'h40400000, mk(32'h41100000, 1'b0, 1'b0, 1'b0));
    send(32'h40800000, 32'h3E800000, mk(32'h3F800000, 1'b0, 1'b0, 1'b0));
    send(32'h41200000, 32'h41200000, mk(32'h42C80000, 1'b0, 1'b0, 1'b0));
    send(32'hBF800000, 32'hBF800000, mk(32'h3F800000, 1'b0, 1'b0, 1'b0));
    stall_en = 1'b0;
    drain();
    check("backpressure_full", {63'd0, saw_full}, 64'd1);
    check("burst_count", 64'(out_count), 64'd8);

    // reset with operations in flight
    send(32'h40000000, 32'h40000000, mk(32'h40800000, 1'b0, 1'b0, 1'b0));
    send(32'h40400000, 32'h40000000, mk(32'h40C00000, 1'b0, 1'b0, 1'b0));
    send(32'h3F800000, 32'h40400000, mk(32'h40400000, 1'b0, 1'b0, 1'b0));
    tick();
    rst_n = 1'b0;
    #1;
    check("reset_kills_valid", {63'd0, bus.out_valid}, 64'd0);
    sb.delete();
    stalled = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_count = 0;
    repeat (8) tick();
    check("no_output_after_reset", 64'(out_count), 64'd0);
    send(32'h40000000, 32'h40400000, mk(32'h40C00000, 1'b0, 1'b0, 1'b0));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
